pipe_stage_reg: RTL

Parametrised pipeline stage register, the generic successor to the fixed ID/EX latch. It carries a DATA_W-bit payload plus a CTRL_W-bit control vector between any two pipeline stages. It adds a valid/ready handshake with a one-entry skid buffer, so backpressure need not be combinational. It also provides a masked control-kill (bubble insertion), a synchronous flush, occupancy reporting and a saturating stall-cycle counter. It is instantiated at IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Pipeline stage register with valid/ready handshake, one-entry
//               skid buffer, masked kill, flush, occupancy and stall counter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
   parameter int                 DATA_W    = 16,
   parameter int                 CTRL_W    = 8,
   parameter logic [CTRL_W-1:0]  ZERO_MASK = {CTRL_W{1'b1}},
   parameter int                 CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              kill_in,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              cnt_clr
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;
   logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
   logic              s_valid_q, s_valid_d;
   logic [DATA_W-1:0] s_data_q,  s_data_d;
   logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic              w_accept;
   logic              w_drain;
   logic              w_stall;
   logic [CTRL_W-1:0] w_cap_ctrl;

   // in_ready depends on registered state only, never on out_ready.
   assign in_ready   = ~s_valid_q;
   assign w_accept   = in_valid & in_ready & ~flush;
   assign w_drain    = m_valid_q & out_ready;
   assign w_stall    = m_valid_q & ~out_ready & ~flush;
   assign w_cap_ctrl = kill_in ? (in_ctrl & ~ZERO_MASK) : in_ctrl;

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_ctrl_d  = m_ctrl_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_ctrl_d  = s_ctrl_q;

      if (flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
         m_ctrl_d  = m_ctrl_q & ~ZERO_MASK;
         s_ctrl_d  = s_ctrl_q & ~ZERO_MASK;
      end else if (w_drain) begin
         if (s_valid_q) begin
            m_data_d  = s_data_q;
            m_ctrl_d  = s_ctrl_q;
            s_valid_d = 1'b0;
         end else if (w_accept) begin
            m_data_d  = in_data;
            m_ctrl_d  = w_cap_ctrl;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (w_accept) begin
         if (!m_valid_q) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
            m_ctrl_d  = w_cap_ctrl;
         end else begin
            // Main is occupied and not draining: the younger entry waits in skid.
            s_valid_d = 1'b1;
            s_data_d  = in_data;
            s_ctrl_d  = w_cap_ctrl;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (cnt_clr) begin
         stall_cnt_d = '0;
      end else if (w_stall && (stall_cnt_q != C_CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_ctrl_q    <= '0;
         s_valid_q   <= 1'b0;
         s_data_q    <= '0;
         s_ctrl_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_ctrl_q    <= m_ctrl_d;
         s_valid_q   <= s_valid_d;
         s_data_q    <= s_data_d;
         s_ctrl_q    <= s_ctrl_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = m_valid_q;
   assign out_data  = m_data_q;
   assign out_ctrl  = m_ctrl_q;
   assign occ       = {1'b0, m_valid_q} + {1'b0, s_valid_q};
   assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire
